// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests 64-byte lines on the system bus, splits each
// 64-bit beat into two 32-bit instructions and feeds decode from a FIFO.
module fetch_unit #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = 8,
   parameter int QDEPTH         = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               entry,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack,
   input  logic                      redirect,
   input  logic [63:0]               redirect_pc,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [31:0]               instr_out,
   output logic [63:0]               instr_pc,
   output logic                      halted
);

   // state | meaning
   // IDLE  | wait for queue room  | REQ  | line request held until acked
   // RESP  | accept line beats    | DRAIN| discard beats after redirect | HALT | end of program
   localparam int LINE_BYTES = BEATS * 8;
   localparam int LOFF       = $clog2(LINE_BYTES);
   localparam int SKW        = LOFF - 2;
   localparam int CW         = $clog2(BEATS) + 1;
   localparam int PW         = $clog2(QDEPTH);
   localparam int NW         = PW + 1;
   localparam logic [3:0] SYSBUS_MEMORY = 4'h0;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN, S_HALT} state_t;

   state_t         r_state, w_state_nxt;
   logic [63:0]    r_line_pc;
   logic [63:0]    r_req_addr;
   logic [SKW-1:0] r_skip;
   logic           r_halt_seen;
   logic           r_drain_pend;
   logic [CW-1:0]  r_beat_cnt, w_beat_cnt_nxt;
   logic [31:0]    r_q_instr [QDEPTH];
   logic [63:0]    r_q_pc    [QDEPTH];
   logic [PW-1:0]  r_head, r_tail;
   logic [NW-1:0]  r_count;

   logic           w_beat, w_last, w_zero, w_capture;
   logic           w_enq0, w_enq1, w_pop;
   logic [SKW-1:0] w_widx0, w_widx1;
   logic [63:0]    w_pc0;
   logic [NW-1:0]  w_free;
   logic [PW-1:0]  w_tail1;
   logic           w_unused;

   assign w_unused  = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

   assign w_beat    = bus_respcyc && (r_state == S_RESP || r_state == S_DRAIN);
   assign w_last    = w_beat && (r_beat_cnt == CW'(BEATS - 1));
   assign w_zero    = (bus_resp == '0);
   // A zero beat ends the program; once seen, the rest of the line is dropped.
   assign w_capture = w_beat && (r_state == S_RESP) && !redirect && !r_halt_seen && !w_zero;
   assign w_widx0   = {r_beat_cnt[CW-2:0], 1'b0};
   assign w_widx1   = {r_beat_cnt[CW-2:0], 1'b1};
   assign w_enq0    = w_capture && (w_widx0 >= r_skip);
   assign w_enq1    = w_capture && (w_widx1 >= r_skip);
   assign w_pc0     = r_line_pc + {{(64-SKW-2){1'b0}}, w_widx0, 2'b00};
   assign w_tail1   = r_tail + PW'(w_enq0);
   assign w_pop     = (r_count != '0) && instr_ready && !redirect;
   assign w_free    = NW'(QDEPTH) - r_count;

   always_comb begin
      w_state_nxt    = r_state;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         S_IDLE: begin
            if (!redirect) begin
               if (r_halt_seen)                       w_state_nxt = S_HALT;
               else if (w_free >= NW'(2 * BEATS))     w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus_reqack) begin
               w_beat_cnt_nxt = '0;
               w_state_nxt    = (r_drain_pend || redirect) ? S_DRAIN : S_RESP;
            end
         end
         S_RESP, S_DRAIN: begin
            if (w_beat) w_beat_cnt_nxt = r_beat_cnt + CW'(1);
            if (w_last)        w_state_nxt = S_IDLE;
            else if (redirect) w_state_nxt = S_DRAIN;
         end
         S_HALT: begin
            if (redirect) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_beat_cnt   <= '0;
         r_line_pc    <= {entry[63:LOFF], {LOFF{1'b0}}};
         r_skip       <= entry[LOFF-1:2];
         r_halt_seen  <= 1'b0;
         r_drain_pend <= 1'b0;
         r_req_addr   <= '0;
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         if (r_state == S_IDLE && w_state_nxt == S_REQ) r_req_addr <= r_line_pc;
         // The request in flight keeps its old address; the redirect drains it.
         if (r_state == S_REQ) r_drain_pend <= !bus_reqack && (r_drain_pend || redirect);

         if (redirect) begin
            r_line_pc   <= {redirect_pc[63:LOFF], {LOFF{1'b0}}};
            r_skip      <= redirect_pc[LOFF-1:2];
            r_halt_seen <= 1'b0;
         end else if (r_state == S_RESP && w_beat) begin
            if (w_zero) r_halt_seen <= 1'b1;
            if (w_last) begin
               r_line_pc <= r_line_pc + 64'(LINE_BYTES);
               r_skip    <= '0;
            end
         end

         if (redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_pop) r_head <= r_head + PW'(1);
            r_tail  <= r_tail + PW'(w_enq0) + PW'(w_enq1);
            r_count <= r_count + NW'(w_enq0) + NW'(w_enq1) - NW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq0) begin
         r_q_instr[r_tail] <= bus_resp[31:0];
         r_q_pc[r_tail]    <= w_pc0;
      end
      if (w_enq1) begin
         r_q_instr[w_tail1] <= bus_resp[63:32];
         r_q_pc[w_tail1]    <= w_pc0 + 64'd4;
      end
   end

   assign bus_reqcyc  = (r_state == S_REQ);
   assign bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(r_req_addr) : '0;
   assign bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'({1'b1, SYSBUS_MEMORY, 8'h00}) : '0;
   assign bus_respack = w_beat;
   assign instr_valid = (r_count != '0);
   assign instr_out   = instr_valid ? r_q_instr[r_head] : '0;
   assign instr_pc    = instr_valid ? r_q_pc[r_head] : '0;
   assign halted      = (r_state == S_HALT) && (r_count == '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bus/memory model, expected-instruction scoreboard,
// a table of straight-line fetch scenarios and hand-written corner sequences.
`timescale 1ns/1ps
module tb_fetch_unit;
   localparam int          BEATS   = 8;
   localparam logic [63:0] NO_ZERO = 64'hFFFF_FFFF_FFFF_FFF8;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } exp_t;

   typedef struct {
      logic [63:0] entry;
      logic [63:0] zero_addr;
      logic [63:0] first_pc;
      int          n_instr;
      logic [63:0] req0;
      logic [63:0] req1;
      bit          halt;
   } row_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] entry;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        bus_respack;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [63:0] instr_pc;
   logic        halted;

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        sb[$];
   logic [63:0] req_log[$];
   int          ack_log[$];
   int          ack_cnt    = 0;
   int          stable_err = 0;
   int          bm_phase, bm_wait, bm_beat;
   logic [63:0] bm_addr, bm_first;
   logic [12:0] bm_tag = '0;
   logic [63:0] zero_addr = NO_ZERO;
   bit          ready_en = 1'b0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .entry       (entry),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .halted      (halted)
   );

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return {8'hC3, a[23:0]};
   endfunction

   function automatic logic [63:0] beat_data(input logic [63:0] a);
      if (a == zero_addr) return 64'h0;
      return {word_at(a + 64'd4), word_at(a)};
   endfunction

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push_seq(input logic [63:0] pc0, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.pc    = pc0 + 64'(4 * k);
         e.instr = word_at(e.pc);
         sb.push_back(e);
      end
   endtask

   task automatic wait_sb(input string name, input int max);
      int i = 0;
      while (sb.size() != 0 && i < max) begin
         @(negedge clk); #3;
         i++;
      end
      check_eq(name, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic wait_req(input string name, input int n, input int max);
      int i = 0;
      while (req_log.size() < n && i < max) begin
         @(negedge clk); #3;
         i++;
      end
      check_eq(name, 64'(req_log.size() >= n), 64'd1);
   endtask

   task automatic rst_assert(input logic [63:0] e);
      reset    = 1'b1;
      entry    = e;
      redirect = 1'b0;
      #1;
      check_eq("reset_ctrl_outputs",
               64'({bus_reqcyc, bus_respack, bus_reqtag, instr_valid, halted}), 64'd0);
      check_eq("reset_data_outputs", bus_req | instr_pc | {32'h0, instr_out}, 64'd0);
      sb.delete();
      req_log.delete();
      ack_log.delete();
      ack_cnt = 0;
   endtask

   task automatic rst_release();
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;
   endtask

   // Memory/bus model: grants each request on its third cycle, then streams 8 beats.
   initial begin
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      bus_resp    = '0;
      bus_resptag = '0;
      bm_phase    = 0;
      bm_wait     = 0;
      bm_beat     = -1;
      bm_addr     = '0;
      bm_first    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus_reqack  = 1'b0;
            bus_respcyc = 1'b0;
            bus_resp    = '0;
            bm_phase    = 0;
            bm_wait     = 0;
            bm_beat     = -1;
         end else if (bm_phase == 0) begin
            if (bus_reqcyc) begin
               if (bm_wait == 0) bm_first = bus_req;
               else if (bus_req != bm_first) stable_err++;
               if (bm_wait == 2) begin
                  bus_reqack = 1'b1;
                  bm_addr    = bus_req;
                  bm_tag     = bus_reqtag;
                  req_log.push_back(bus_req);
                  ack_log.push_back(ack_cnt);
                  bm_wait    = 0;
                  bm_phase   = 1;
               end else begin
                  bm_wait++;
               end
            end else if (bm_wait != 0) begin
               stable_err++;
            end
         end else begin
            bus_reqack = 1'b0;
            bm_beat    = (bm_phase == 1) ? 0 : bm_beat + 1;
            bm_phase   = 2;
            if (bm_beat == BEATS) begin
               bus_respcyc = 1'b0;
               bus_resp    = '0;
               bm_beat     = -1;
               bm_phase    = 0;
            end else begin
               bus_respcyc = 1'b1;
               bus_resp    = beat_data(bm_addr + 64'(8 * bm_beat));
               bus_resptag = bm_tag;
               #1;
               if (bus_respack) ack_cnt++;
            end
         end
      end
   end

   // Decode side: pops only while an expected entry is waiting.
   initial begin
      exp_t e;
      instr_ready = 1'b0;
      forever begin
         @(negedge clk);
         instr_ready = ready_en && (sb.size() > 0);
         #2;
         if (instr_valid && instr_ready) begin
            e = sb.pop_front();
            check_eq("instr_out", 64'(instr_out), 64'(e.instr));
            check_eq("instr_pc", instr_pc, e.pc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t rows [3];
      int   i;
      reset       = 1'b1;
      entry       = '0;
      redirect    = 1'b0;
      redirect_pc = '0;

      rows[0] = '{entry: 64'h1000, zero_addr: NO_ZERO, first_pc: 64'h1000, n_instr: 16,
                  req0: 64'h1000, req1: 64'h1040, halt: 1'b0};
      rows[1] = '{entry: 64'h1008, zero_addr: NO_ZERO, first_pc: 64'h1008, n_instr: 14,
                  req0: 64'h1000, req1: 64'h1040, halt: 1'b0};
      rows[2] = '{entry: 64'h2000, zero_addr: 64'h2018, first_pc: 64'h2000, n_instr: 6,
                  req0: 64'h2000, req1: 64'h0, halt: 1'b1};

      for (int r = 0; r < 3; r++) begin
         zero_addr = rows[r].zero_addr;
         ready_en  = 1'b1;
         @(negedge clk); #3;
         rst_assert(rows[r].entry);
         rst_release();
         push_seq(rows[r].first_pc, rows[r].n_instr);
         wait_sb("row_stream", 400);
         if (rows[r].halt) begin
            i = 0;
            while (!halted && i < 60) begin
               @(negedge clk); #3;
               i++;
            end
            check_eq("row_halted", 64'(halted), 64'd1);
            repeat (40) @(negedge clk);
            #3;
            check_eq("halt_req_count", 64'(req_log.size()), 64'd1);
            check_eq("halt_reqcyc", 64'(bus_reqcyc), 64'd0);
            check_eq("halt_respacks", 64'(ack_cnt), 64'd8);
            check_eq("halt_valid", 64'(instr_valid), 64'd0);
         end else begin
            wait_req("row_second_req", 2, 100);
            check_eq("row_req1", (req_log.size() > 1) ? req_log[1] : '1, rows[r].req1);
            check_eq("row_line0_respacks", 64'((ack_log.size() > 1) ? ack_log[1] : -1), 64'd8);
         end
         check_eq("row_req0", (req_log.size() > 0) ? req_log[0] : '1, rows[r].req0);
         check_eq("row_tag", 64'(bm_tag), 64'h1000);
      end

      // Decode stalled: two lines fill the queue, the 16th pop reopens fetch.
      zero_addr = NO_ZERO;
      ready_en  = 1'b0;
      @(negedge clk); #3;
      rst_assert(64'h5000);
      rst_release();
      repeat (150) @(negedge clk);
      #3;
      check_eq("full_req_count", 64'(req_log.size()), 64'd2);
      check_eq("full_reqcyc", 64'(bus_reqcyc), 64'd0);
      push_seq(64'h5000, 15);
      ready_en = 1'b1;
      wait_sb("full_pop15", 100);
      repeat (20) @(negedge clk);
      #3;
      check_eq("full_req_count_15", 64'(req_log.size()), 64'd2);
      check_eq("full_reqcyc_15", 64'(bus_reqcyc), 64'd0);
      push_seq(64'h503C, 1);
      wait_sb("full_pop16", 20);
      wait_req("full_third_req", 3, 30);
      check_eq("full_req2", (req_log.size() > 2) ? req_log[2] : '1, 64'h5080);

      // Redirect during beat 5.
      ready_en = 1'b0;
      @(negedge clk); #3;
      rst_assert(64'h6000);
      rst_release();
      i = 0;
      while (!(bm_beat == 5 && bus_respcyc) && i < 100) begin
         @(negedge clk); #3;
         i++;
      end
      check_eq("redir_beat5", 64'(bm_beat), 64'd5);
      redirect    = 1'b1;
      redirect_pc = 64'h3004;
      @(negedge clk); #3;
      redirect = 1'b0;
      check_eq("redir_flush", 64'(instr_valid), 64'd0);
      wait_req("redir_new_req", 2, 60);
      check_eq("redir_empty_at_req", 64'(instr_valid), 64'd0);
      check_eq("redir_req", (req_log.size() > 1) ? req_log[1] : '1, 64'h3000);
      check_eq("redir_respacks", 64'((ack_log.size() > 1) ? ack_log[1] : -1), 64'd8);
      push_seq(64'h3004, 15);
      ready_en = 1'b1;
      wait_sb("redir_stream", 100);

      // Reset in the middle of a burst.
      ready_en = 1'b0;
      @(negedge clk); #3;
      rst_assert(64'h7000);
      rst_release();
      i = 0;
      while (!(bm_beat == 3 && bus_respcyc) && i < 100) begin
         @(negedge clk); #3;
         i++;
      end
      check_eq("midrst_beat3", 64'(bm_beat), 64'd3);
      rst_assert(64'h4000);
      rst_release();
      wait_req("midrst_new_req", 1, 40);
      check_eq("midrst_req", (req_log.size() > 0) ? req_log[0] : '1, 64'h4000);
      push_seq(64'h4000, 16);
      ready_en = 1'b1;
      wait_sb("midrst_stream", 200);

      check_eq("req_stable", 64'(stable_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
